// File: rtl/softmax_feeder.sv
// Softmax feeder: buffers N logits plus a label, streams them word-serially to softmax,
// captures the predicted class, collects the backprop error words and replays them upstream.
module softmax_feeder #(
  parameter int N       = 4,
  parameter int IDX_W   = 3,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              logit_valid,
  output logic              logit_ready,
  input  logic [DATA_W-1:0] logit_data,
  input  logic [IDX_W-1:0]  label_in,
  output logic [DATA_W-1:0] sf_input,
  output logic [IDX_W-1:0]  sf_input_idx,
  output logic              start,
  input  logic              in_ready,
  output logic              backprop_ctrl,
  output logic [IDX_W-1:0]  expected_label,
  input  logic [IDX_W-1:0]  max,
  input  logic              max_ready,
  input  logic              out_ready,
  input  logic [IDX_W-1:0]  out_idx,
  input  logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  pred,
  output logic              pred_valid,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [IDX_W-1:0]  err_idx,
  output logic [DATA_W-1:0] err_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_N   = IDX_W'(N);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FWD,
    FWD_GAP,
    WAIT_MAX,
    BWD,
    EMIT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] lbuf [N];
  logic [DATA_W-1:0] ebuf [N];
  logic [IDX_W-1:0]  k;
  logic [IDX_W-1:0]  i;
  logic [IDX_W-1:0]  j;
  logic [IDX_W-1:0]  label;
  logic [TW-1:0]     wd;
  logic [IDX_W-1:0]  i_next;
  logic [IDX_W-1:0]  j_next;

  assign i_next = i + IDX_W'(1);
  assign j_next = j + IDX_W'(1);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      logit_ready    <= 1'b0;
      sf_input       <= '0;
      sf_input_idx   <= '0;
      start          <= 1'b0;
      backprop_ctrl  <= 1'b0;
      expected_label <= '0;
      pred           <= '0;
      pred_valid     <= 1'b0;
      err_valid      <= 1'b0;
      err_idx        <= '0;
      err_data       <= '0;
      timeout_err    <= 1'b0;
      k              <= '0;
      i              <= '0;
      j              <= '0;
      label          <= '0;
      wd             <= '0;
      for (int n = 0; n < N; n++) begin
        lbuf[n] <= '0;
        ebuf[n] <= '0;
      end
    end else begin
      pred_valid <= 1'b0;
      case (state)
        IDLE: begin
          logit_ready <= 1'b1;
          if (logit_valid && logit_ready) begin
            lbuf[0]     <= logit_data;
            label       <= label_in;
            timeout_err <= 1'b0;
            k           <= IDX_W'(1);
            state       <= LOAD;
          end
        end

        LOAD: begin
          if (logit_valid && logit_ready) begin
            lbuf[k[AW-1:0]] <= logit_data;
            if (k == LAST) begin
              // Word 0 is already buffered, so the first request can go out next cycle.
              logit_ready    <= 1'b0;
              i              <= '0;
              sf_input       <= lbuf[0];
              sf_input_idx   <= '0;
              expected_label <= label;
              backprop_ctrl  <= 1'b0;
              start          <= in_ready;
              state          <= FWD;
            end else begin
              k <= k + IDX_W'(1);
            end
          end
        end

        FWD: begin
          if (start && in_ready) begin
            start <= 1'b0;
            if (i == LAST) begin
              wd    <= '0;
              state <= WAIT_MAX;
            end else begin
              i            <= i_next;
              sf_input     <= lbuf[i_next[AW-1:0]];
              sf_input_idx <= i_next;
              state        <= FWD_GAP;
            end
          end else if (!start) begin
            start <= in_ready;
          end
        end

        FWD_GAP: begin
          start <= in_ready;
          state <= FWD;
        end

        WAIT_MAX: begin
          if (max_ready) begin
            pred          <= max;
            pred_valid    <= 1'b1;
            backprop_ctrl <= 1'b1;
            wd            <= '0;
            state         <= BWD;
          end else if (wd == TO_LAST) begin
            timeout_err   <= 1'b1;
            backprop_ctrl <= 1'b0;
            logit_ready   <= 1'b1;
            state         <= IDLE;
          end else begin
            wd <= wd + TW'(1);
          end
        end

        BWD: begin
          start <= out_ready && backprop_ctrl;
          if (out_ready) begin
            wd <= '0;
          end else if (wd == TO_LAST) begin
            timeout_err   <= 1'b1;
            backprop_ctrl <= 1'b0;
            start         <= 1'b0;
            logit_ready   <= 1'b1;
            state         <= IDLE;
          end else begin
            wd <= wd + TW'(1);
          end
          // Out-of-range indices are dropped; only the last index ends the phase.
          if (start && out_ready && (out_idx < IDX_N)) begin
            ebuf[out_idx[AW-1:0]] <= out_data;
            if (out_idx == LAST) begin
              backprop_ctrl <= 1'b0;
              start         <= 1'b0;
              j             <= '0;
              err_valid     <= 1'b1;
              err_idx       <= '0;
              err_data      <= (out_idx == '0) ? out_data : ebuf[0];
              state         <= EMIT;
            end
          end
        end

        EMIT: begin
          if (err_ready) begin
            if (j == LAST) begin
              err_valid   <= 1'b0;
              logit_ready <= 1'b1;
              state       <= IDLE;
            end else begin
              j        <= j_next;
              err_idx  <= j_next;
              err_data <= ebuf[j_next[AW-1:0]];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/softmax_feeder.md
Name: softmax_feeder

Overview:
- Initiator for the softmax layer's word-serial handshake, driving the other end of that interface.
- Buffers N logits and the training label from the upstream FC stage, then transmits the logits to softmax one index at a time.
- Captures the predicted class (max), runs the backprop phase, and collects N error words.
- Streams the error words to the upstream layer's backprop input.

Parameters:
N, 4, number of classes/logits
IDX_W, 3, index width (covers 0..N, so N=4 needs 3 bits)
DATA_W, 32, data width (Q16.16 signed fixed point)
TIMEOUT, 1024, max cycles to wait for max_ready or out_ready before flagging error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
logit_valid  in  1  upstream logit word valid
logit_ready  out  1  feeder can accept a logit
logit_data  in  DATA_W  logit value, accepted in index order 0..N-1
label_in  in  IDX_W  expected label, sampled with logit index 0
sf_input  out  DATA_W  logit to softmax
sf_input_idx  out  IDX_W  index of sf_input
start  out  1  transfer request strobe to softmax
in_ready  in  1  softmax ready for a forward word
backprop_ctrl  out  1  0=forward phase, 1=backprop phase
expected_label  out  IDX_W  label to softmax
max  in  IDX_W  predicted class from softmax
max_ready  in  1  max valid
out_ready  in  1  softmax error word available
out_idx  in  IDX_W  index of out_data
out_data  in  DATA_W  error word from softmax
pred  out  IDX_W  captured max
pred_valid  out  1  one-cycle pulse when max is captured
err_valid  out  1  error stream valid
err_ready  in  1  downstream accepts error
err_idx  out  IDX_W  error index
err_data  out  DATA_W  error value
busy  out  1  high in any state other than IDLE
timeout_err  out  1  sticky until next logit accepted in IDLE

Behaviour:
- Reset (rst=0, async) forces the following, with buffers cleared to 0:
  - state=IDLE
  - all outputs 0: sf_input, sf_input_idx, start, backprop_ctrl, expected_label, pred, pred_valid, err_*, busy, timeout_err
  - logit_ready=0
- Reset during any state aborts the operation and discards partial data; no further start pulses are issued.
- IDLE:
  - logit_ready=1.
  - A logit_valid&logit_ready beat writes buf[0], latches label_in, clears timeout_err, and moves to LOAD.
- LOAD:
  - logit_ready=1.
  - Each accepted beat writes buf[k], k=1..N-1.
  - After buf[N-1] is written: logit_ready=0 on the next cycle, i=0, go to FWD.
- FWD:
  - sf_input=buf[i], sf_input_idx=i, backprop_ctrl=0, expected_label=label.
  - When in_ready=1, assert start.
  - A word transfers on a rising edge with start=1 & in_ready=1.
  - On the cycle after a transfer, start drops to 0 for exactly one cycle (FWD_GAP) and i increments.
  - sf_input/sf_input_idx are stable while start=1.
  - After the transfer with i=N-1, go to WAIT_MAX with start=0.
- WAIT_MAX:
  - On the first cycle max_ready=1: pred<=max, pred_valid pulses 1 cycle, backprop_ctrl<=1, go to BWD.
  - The watchdog counts cycles; on reaching TIMEOUT, set timeout_err, drop backprop_ctrl, go to IDLE.
- BWD:
  - When out_ready=1 and backprop_ctrl=1, assert start.
  - A word is captured on an edge with start=1 & out_ready=1: ebuf[out_idx]<=out_data.
  - out_idx >= N is ignored, with no write.
  - After capturing out_idx==N-1: backprop_ctrl<=0, start<=0, j=0, go to EMIT.
  - If out_ready is low for TIMEOUT consecutive cycles: timeout_err, go to IDLE.
- EMIT:
  - err_valid=1, err_idx=j, err_data=ebuf[j].
  - err_idx and err_data are held while err_valid=1 & err_ready=0.
  - On each err_ready beat j increments; after j=N-1 is accepted, err_valid=0 and go to IDLE.
- Latency: from the last logit accepted to the first start is 1–2 cycles, depending on in_ready.
- A max_ready that arrives in FWD is ignored; only WAIT_MAX samples it.
- Simultaneous last logit beat and in_ready: the forward phase begins the next cycle.
- No arithmetic on data; words pass through bit-exact.

Test Plan:
- Basic forward:
  - Stimulus: logits 0x00008000, 0x00010F00, 0x00019E00, 0x00022D00, label 0, in_ready held 1.
  - Required: four transfers with idx 0..3 and start low one cycle between them.
  - With max=3 and max_ready: pred=3, pred_valid pulses once, backprop_ctrl rises.
- Backprop capture:
  - Stimulus: out_ready=1, softmax returns out_idx 0..3 with data 0xFFFF8000, 0x00002000, 0x00003000, 0x00003000.
  - Required: backprop_ctrl falls after idx 3; err stream emits the same 4 values in order with err_ready=1.
- Backpressure:
  - in_ready toggles 1/0 every 3 cycles -> no transfer while in_ready=0, sf_input stable, still exactly 4 transfers.
  - err_ready low for 5 cycles -> err_idx/err_data held constant.
- Timeout:
  - Stimulus: never assert max_ready.
  - Required: after 1024 cycles in WAIT_MAX, timeout_err=1, state IDLE, logit_ready=1.
- Reset mid-operation:
  - Stimulus: drive rst=0 asynchronously after the 2nd forward transfer.
  - Required: all outputs 0 immediately; after release, a fresh 4-logit load runs cleanly.
- Out-of-range index:
  - Stimulus: out_idx=5 during BWD.
  - Required: ignored, no buffer write, BWD continues until idx 3 is captured.
